// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the cpu_sequencer block: sequencer state encoding,
// instruction width and the instruction word that stops the machine.
package cpu_sequencer_pkg;

  localparam int INST_W = 32;

  // An all-zero instruction word parks the sequencer in HALT.
  localparam logic [INST_W-1:0] HALT_INST = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } seq_state_e;

  // States in which the sequencer waits on a memory acknowledge.
  function automatic logic is_wait_state(input seq_state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Memory-side bundle of the cpu_sequencer: instruction fetch handshake and
// data-memory strobes/acknowledge. master = sequencer, slave = memories.
interface cpu_sequencer_if #(
  parameter int PC_W = 32
);
  import cpu_sequencer_pkg::*;

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              dmem_rd_en;
  logic              dmem_wr_en;
  logic              dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_rd_en, dmem_wr_en,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_rd_en, dmem_wr_en,
    output imem_ack, imem_rdata, dmem_ack
  );

endinterface

// File: rtl/cpu_sequencer_seq_wait_timer.sv
// Acknowledge wait timer: counts cycles spent waiting in FETCH or MEM and
// flags a timeout when the count would reach WAIT_MAX without an ack.
// An ack in that same cycle wins, so expire is suppressed by ack.
module seq_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,    // entering a wait state this cycle
  input  logic active,   // currently in a wait state
  input  logic ack,      // acknowledge for the current wait state
  output logic expire
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W:0] LIMIT = WAIT_MAX[CNT_W:0];

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   cnt_inc_s;

  assign cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign expire    = active && !ack && (cnt_inc_s == LIMIT);

  // Next count: clear on entry, count each un-acked waiting cycle, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (active && !ack) begin
      cnt_d = cnt_inc_s[CNT_W-1:0];
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer
// (IDLE/FETCH/DECODE/EXEC/MEM/WB, absorbing HALT and FAULT).
// Optional macro SINGLE_STEP_EN: adds the step port; each registered 0->1
// edge of step releases exactly one instruction from IDLE. Without it the
// sequencer free-runs.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  cpu_sequencer_if.master   bus,
  output logic [INST_W-1:0] inst,
  input  logic              ctl_branch,
  input  logic              ctl_mem_read,
  input  logic              ctl_mem_write,
  input  logic              ctl_reg_write,
  input  logic              alu_zero,
  input  logic [PC_W-1:0]   branch_addr,
  output logic              reg_wr_en,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              fault
);

  seq_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              imem_req_q;
  logic              halted_q;
  logic              fault_q;
  logic              go_s;
  logic              timer_clear_s;
  logic              timer_active_s;
  logic              timer_ack_s;
  logic              timer_expire_s;

`ifdef SINGLE_STEP_EN
  logic step_q, step_prev_q;
  logic step_pend_q, step_pend_d;

  // A pending step is consumed by IDLE->FETCH; a new registered rise re-arms it.
  always_comb begin
    if ((state_q == ST_IDLE) && step_pend_q) begin
      step_pend_d = 1'b0;
    end else begin
      step_pend_d = step_pend_q;
    end
    if (step_q && !step_prev_q) begin
      step_pend_d = 1'b1;
    end else begin
      step_pend_d = step_pend_d;
    end
  end

  // Step synchroniser, edge history and pending-step flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q      <= 1'b0;
      step_prev_q <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_q      <= step;
      step_prev_q <= step_q;
      step_pend_q <= step_pend_d;
    end
  end

  assign go_s = step_pend_q;
`else
  logic start_q;

  // Holds IDLE for one edge after reset release so the first FETCH starts on
  // the second rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b1;
    end
  end

  assign go_s = start_q;
`endif

  // Only FETCH/MEM acknowledges are seen by the timer; others are ignored.
  assign timer_active_s = is_wait_state(state_q);
  assign timer_ack_s    = (state_q == ST_MEM) ? bus.dmem_ack : bus.imem_ack;
  assign timer_clear_s  = is_wait_state(state_d) && (state_d != state_q);

  seq_wait_timer #(
    .WAIT_MAX (MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear_s),
    .active (timer_active_s),
    .ack    (timer_ack_s),
    .expire (timer_expire_s)
  );

  // Next-state, instruction-register and program-counter logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      ST_IDLE: begin
        state_d = go_s ? ST_FETCH : ST_IDLE;
      end
      ST_FETCH: begin
        if (bus.imem_ack) begin
          inst_d  = bus.imem_rdata;
          state_d = ST_DECODE;
        end else if (timer_expire_s) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        state_d = (inst_q == HALT_INST) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        state_d = (ctl_mem_read || ctl_mem_write) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (bus.dmem_ack) begin
          state_d = ST_WB;
        end else if (timer_expire_s) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
        // Word-addressed increment; natural wrap from all-ones to zero.
        pc_d = (ctl_branch && alu_zero) ? branch_addr : pc_q + PC_W'(1);
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // Sequencer state plus registered status outputs derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= {PC_W{1'b0}};
      inst_q     <= {INST_W{1'b0}};
      imem_req_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      imem_req_q <= (state_d == ST_FETCH);
      halted_q   <= (state_d == ST_HALT);
      fault_q    <= (state_d == ST_FAULT);
    end
  end

  // Strobes gate the live decoded controls with the registered state, so the
  // controls are never captured and each strobe is confined to its one state.
  assign bus.dmem_rd_en = (state_q == ST_MEM) && ctl_mem_read;
  assign bus.dmem_wr_en = (state_q == ST_MEM) && ctl_mem_write;
  assign reg_wr_en      = (state_q == ST_WB) && ctl_reg_write;

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign pc            = pc_q;
  assign inst          = inst_q;
  assign halted        = halted_q;
  assign fault         = fault_q;

endmodule
